calc_sequencer: RTL and testbench

- Upstream feeder and result collector for the 4-bit registered calculator stage.
- Buffers operand/mode commands in a small FIFO behind a valid/ready handshake.
- Issues one command at a time to the calculator on registered a/b/MODO lines, waits out its one-cycle registered latency, and captures {rco,c}.
- Presents each captured result, tagged with a sequence number, on a valid/ready output handshake.

---
 rtl/calc_sequencer.sv | 122 ++++++++++++
 tb/tb_calc_sequencer.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
`timescale 1ns/1ps
// calc_sequencer: buffers operand/mode commands, issues them one at a time to the
// registered 4-bit calculator, and returns tagged {rco,c} results over valid/ready.
module calc_sequencer #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [3:0]             cmd_a,
    input  logic [3:0]             cmd_b,
    input  logic [1:0]             cmd_modo,
    output logic [3:0]             calc_a,
    output logic [3:0]             calc_b,
    output logic [1:0]             calc_modo,
    input  logic [3:0]             calc_c,
    input  logic                   calc_rco,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [3:0]             res_c,
    output logic                   res_rco,
    output logic [1:0]             res_modo,
    output logic [TAG_W-1:0]       res_tag,
    output logic                   busy,
    output logic [$clog2(DEPTH):0] fifo_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] modo;
    } cmd_t;

    state_t           state;
    cmd_t             mem [DEPTH];
    cmd_t             head;
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [TAG_W-1:0] tag_cnt;
    logic             push;
    logic             pop;

    // Ready comes from the registered count only, so a same-cycle pop never raises it.
    assign cmd_ready = fifo_count < CW'(DEPTH);
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state == IDLE) && (fifo_count != '0);
    assign busy      = (state != IDLE) || (fifo_count != '0);
    assign head      = mem[rd_ptr];

    // NOTE: the storage array has no reset; the pointers and count decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: cmd_a, b: cmd_b, modo: cmd_modo};
        end
    end

    // NOTE: every register here uses <= so all of them see pre-edge values of each other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            calc_a     <= '0;
            calc_b     <= '0;
            calc_modo  <= '0;
            res_valid  <= 1'b0;
            res_c      <= '0;
            res_rco    <= 1'b0;
            res_modo   <= '0;
            res_tag    <= '0;
            tag_cnt    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CW'(1);
            end else if (pop && !push) begin
                fifo_count <= fifo_count - CW'(1);
            end

            unique case (state)
                IDLE: begin
                    if (pop) begin
                        calc_a    <= head.a;
                        calc_b    <= head.b;
                        calc_modo <= head.modo;
                        state     <= ISSUE;
                    end
                end
                // Operands stay stable this whole cycle; the calculator registers them at its end.
                ISSUE: state <= WAIT;
                WAIT: begin
                    res_c     <= calc_c;
                    res_rco   <= calc_rco;
                    res_modo  <= calc_modo;
                    res_tag   <= tag_cnt;
                    res_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        tag_cnt   <= tag_cnt + TAG_W'(1);
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for calc_sequencer: directed scenarios plus random traffic,
// scored against an in-order queue model of accepted commands.
module tb_calc_sequencer;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic                   clk = 1'b0;
    logic                   rst = 1'b0;
    logic                   cmd_valid = 1'b0;
    logic                   cmd_ready;
    logic [3:0]             cmd_a = '0;
    logic [3:0]             cmd_b = '0;
    logic [1:0]             cmd_modo = '0;
    logic [3:0]             calc_a;
    logic [3:0]             calc_b;
    logic [1:0]             calc_modo;
    logic [3:0]             calc_c;
    logic                   calc_rco;
    logic                   res_valid;
    logic                   res_ready = 1'b0;
    logic [3:0]             res_c;
    logic                   res_rco;
    logic [1:0]             res_modo;
    logic [TAG_W-1:0]       res_tag;
    logic                   busy;
    logic [$clog2(DEPTH):0] fifo_count;

    always #5 clk = ~clk;

    calc_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_modo(cmd_modo),
        .calc_a(calc_a), .calc_b(calc_b), .calc_modo(calc_modo),
        .calc_c(calc_c), .calc_rco(calc_rco),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_c(res_c), .res_rco(res_rco), .res_modo(res_modo), .res_tag(res_tag),
        .busy(busy), .fifo_count(fifo_count)
    );

    // 5-bit {rco,c} the calculator produces for each mode.
    function automatic logic [4:0] calc_fn(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] m);
        logic [7:0] p;
        p = {4'b0, a} * {4'b0, b};
        case (m)
            2'd0:    return {1'b0, a} + {1'b0, b};
            2'd1:    return {1'b0, a} - {1'b0, b};
            2'd2:    return p[4:0];
            default: return {a, 1'b0};
        endcase
    endfunction

    // Stand-in calculator with one cycle of registered latency.
    logic [4:0] calc_q = '0;
    always @(posedge clk) calc_q <= calc_fn(calc_a, calc_b, calc_modo);
    assign calc_c   = calc_q[3:0];
    assign calc_rco = calc_q[4];

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] m;
    } cmd_t;

    cmd_t             exp_q[$];
    logic [TAG_W-1:0] exp_tag = '0;
    int               n_results = 0;
    int               n_checks = 0;
    int               n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Scoreboard: records accepted commands and scores each consumed result in order.
    always @(negedge clk) begin : monitor
        cmd_t       e;
        logic [4:0] r;
        if (rst) begin
            if (cmd_valid && cmd_ready) exp_q.push_back('{cmd_a, cmd_b, cmd_modo});
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    r = calc_fn(e.a, e.b, e.m);
                    check("sb_c", res_c, r[3:0]);
                    check("sb_rco", res_rco, r[4]);
                    check("sb_modo", res_modo, e.m);
                    check("sb_tag", res_tag, exp_tag);
                    exp_tag = exp_tag + 1'b1;
                    n_results++;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // All driving tasks start and end 1ns after a rising edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b0;
        cmd_valid = 1'b0;
        res_ready = 1'b0;
        exp_q.delete();
        exp_tag = '0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic push_cmd(input logic [3:0] a, input logic [3:0] b, input logic [1:0] m);
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_a = a;
        cmd_b = b;
        cmd_modo = m;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = cmd_ready;
        end
        if (!ok) check("push_timeout", 0, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_valid(input string nm);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            seen = res_valid;
        end
        check({nm, "_valid"}, seen, 1);
    endtask

    task automatic wait_result(input logic [3:0] c, input logic r, input logic [1:0] m,
                               input logic [TAG_W-1:0] t, input string nm);
        wait_valid(nm);
        if (res_valid) begin
            check({nm, "_c"}, res_c, c);
            check({nm, "_rco"}, res_rco, r);
            check({nm, "_modo"}, res_modo, m);
            check({nm, "_tag"}, res_tag, t);
        end
    endtask

    task automatic wait_drain(input string nm);
        bit done = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            done = !busy && (exp_q.size() == 0);
        end
        check({nm, "_busy"}, busy, 0);
        check({nm, "_pending"}, exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        logic [3:0]       h_c;
        logic             h_rco;
        logic [1:0]       h_modo;
        logic [TAG_W-1:0] h_tag;
        int               base;
        bit               acc;

        // Reset state
        #12;
        check("rst_async_valid", res_valid, 0);
        check("rst_async_count", fifo_count, 0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_calc_a", calc_a, 0);
        check("rst_res_tag", res_tag, 0);
        @(posedge clk);
        #1;

        // Single add and its latency
        res_ready = 1'b1;
        push_cmd(4'd3, 4'd5, 2'd0);
        @(negedge clk);
        check("t1_count_after_push", fifo_count, 1);
        check("t1_busy", busy, 1);
        @(negedge clk);
        check("t1_issue_a", calc_a, 3);
        check("t1_issue_b", calc_b, 5);
        check("t1_issue_modo", calc_modo, 0);
        check("t1_count_after_pop", fifo_count, 0);
        @(negedge clk);
        check("t1_valid_early", res_valid, 0);
        @(negedge clk);
        check("t1_valid", res_valid, 1);
        check("t1_c", res_c, 8);
        check("t1_rco", res_rco, 0);
        check("t1_tag", res_tag, 0);
        @(negedge clk);
        check("t1_valid_cleared", res_valid, 0);
        check("t1_idle", busy, 0);
        @(posedge clk);
        #1;

        // Overflow and borrow, back to back
        do_reset();
        res_ready = 1'b1;
        fork
            begin
                push_cmd(4'd9, 4'd9, 2'd0);
                push_cmd(4'd2, 4'd3, 2'd1);
                push_cmd(4'd3, 4'd6, 2'd2);
                push_cmd(4'd9, 4'd0, 2'd3);
            end
            begin
                wait_result(4'd2,  1'b1, 2'd0, 4'd0, "t2_add");
                wait_result(4'd15, 1'b1, 2'd1, 4'd1, "t2_sub");
                wait_result(4'd2,  1'b1, 2'd2, 4'd2, "t2_mul");
                wait_result(4'd2,  1'b1, 2'd3, 4'd3, "t2_shl");
            end
        join
        @(posedge clk);
        #1;

        // Input backpressure fills the FIFO, then output stalls in HOLD
        do_reset();
        base = n_results;
        fork
            for (int i = 0; i < 6; i++) push_cmd(4'(i + 1), 4'(i), 2'(i));
        join_none
        repeat (12) @(negedge clk);
        check("t3_count_full", fifo_count, 4);
        check("t3_cmd_ready", cmd_ready, 0);
        check("t3_sixth_held", cmd_valid, 1);
        check("t3_hold_valid", res_valid, 1);
        check("t3_hold_tag", res_tag, 0);
        h_c = res_c;
        h_rco = res_rco;
        h_modo = res_modo;
        h_tag = res_tag;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("t3_stall_c", res_c, h_c);
            check("t3_stall_rco", res_rco, h_rco);
            check("t3_stall_modo", res_modo, h_modo);
            check("t3_stall_tag", res_tag, h_tag);
            check("t3_stall_calc_a", calc_a, 1);
            check("t3_stall_count", fifo_count, 4);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        for (int i = 0; i < 200 && (n_results - base) < 6; i++) @(negedge clk);
        check("t3_result_count", n_results - base, 6);
        wait_drain("t3_drain");

        // Simultaneous push and pop at count 2, walking the write pointer past the wrap
        do_reset();
        push_cmd(4'd1, 4'd1, 2'd0);
        push_cmd(4'd2, 4'd1, 2'd0);
        push_cmd(4'd3, 4'd1, 2'd0);
        wait_valid("t4_first");
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            res_ready = 1'b1;
            @(negedge clk);
            @(posedge clk);
            #1;
            res_ready = 1'b0;
            cmd_valid = 1'b1;
            cmd_a = 4'(r + 4);
            cmd_b = 4'd2;
            cmd_modo = 2'd1;
            @(negedge clk);
            check("t4_count_pre", fifo_count, 2);
            check("t4_ready_pre", cmd_ready, 1);
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            @(negedge clk);
            check("t4_count_post", fifo_count, 2);
            check("t4_pop_a", calc_a, r + 2);
            wait_valid("t4_round");
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        wait_drain("t4_drain");

        // Reset during WAIT with three commands queued
        do_reset();
        for (int i = 0; i < 5; i++) push_cmd(4'd7, 4'd7, 2'd0);
        wait_valid("t5_hold");
        check("t5_count_full", fifo_count, 4);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(negedge clk);
        repeat (3) @(posedge clk);
        #1;
        check("t5_queued_in_wait", fifo_count, 3);
        #1;
        rst = 1'b0;
        exp_q.delete();
        exp_tag = '0;
        #1;
        check("t5_rst_valid", res_valid, 0);
        check("t5_rst_count", fifo_count, 0);
        check("t5_rst_tag", res_tag, 0);
        check("t5_rst_calc_a", calc_a, 0);
        check("t5_rst_calc_b", calc_b, 0);
        check("t5_rst_calc_modo", calc_modo, 0);
        check("t5_rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        check("t5_no_stale_valid", res_valid, 0);
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        push_cmd(4'd1, 4'd1, 2'd0);
        wait_result(4'd2, 1'b0, 2'd0, 4'd0, "t5_after");
        @(posedge clk);
        #1;

        // Random traffic on both handshakes
        do_reset();
        base = n_results;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            acc = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            if (!cmd_valid || acc) begin
                cmd_valid = ($urandom_range(0, 2) != 0);
                cmd_a = 4'($urandom);
                cmd_b = 4'($urandom);
                cmd_modo = 2'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        wait_drain("rnd_drain");
        check("rnd_some_results", (n_results - base) > 20, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
